// File: rtl/alu_dword_sequencer.sv
// alu_dword_sequencer
//   Runs a 64-bit ADD/SUB/AND/ORR as two passes through the shared 32-bit ALU:
//   the low word first, then the high word, with the low-word carry/borrow
//   chained into the high pass through alu_sr[2].
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake; req_ready is high only in IDLE
//   req_op                00 ADD, 01 SUB, 10 AND, 11 ORR
//   req_a, req_b          64-bit operands, captured on accept
//   resp_valid/resp_ready response handshake; the response is held until taken
//   resp_result           64-bit result (registered)
//   resp_status           {z, c, n, v} of the 64-bit operation (registered)
//   alu_val1/alu_val2     ALU operands
//   alu_exe_cmd, alu_sr   ALU command and status-in (bit 2 is carry-in)
//   alu_result/alu_status ALU result and {z, cout, n, v}
module alu_dword_sequencer #(
   parameter int unsigned W = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           req_valid,
   output logic           req_ready,
   input  logic [1:0]     req_op,
   input  logic [2*W-1:0] req_a,
   input  logic [2*W-1:0] req_b,
   output logic           resp_valid,
   input  logic           resp_ready,
   output logic [2*W-1:0] resp_result,
   output logic [3:0]     resp_status,
   output logic [W-1:0]   alu_val1,
   output logic [W-1:0]   alu_val2,
   output logic [3:0]     alu_exe_cmd,
   output logic [3:0]     alu_sr,
   input  logic [W-1:0]   alu_result,
   input  logic [3:0]     alu_status
);

   localparam logic [3:0] CmdNone = 4'b0000;
   localparam logic [3:0] CmdAdd  = 4'b0010;
   localparam logic [3:0] CmdAdc  = 4'b0011;
   localparam logic [3:0] CmdSub  = 4'b0100;
   localparam logic [3:0] CmdSbc  = 4'b0101;
   localparam logic [3:0] CmdAnd  = 4'b0110;
   localparam logic [3:0] CmdOrr  = 4'b0111;

   localparam logic [1:0] OpAdd = 2'b00;
   localparam logic [1:0] OpSub = 2'b01;
   localparam logic [1:0] OpAnd = 2'b10;

   typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

   state_e         state_q, state_d;
   logic [2*W-1:0] a_q, b_q;
   logic [1:0]     op_q;
   logic [W-1:0]   lo_res_q;
   logic           lo_z_q, lo_c_q;
   logic [2*W-1:0] res_q;
   logic [3:0]     status_q;
   logic           is_logic_op;

   assign is_logic_op = op_q[1];

   // Next state and ALU drive; the ALU side depends only on state and captured operands.
   always_comb begin
      state_d     = state_q;
      req_ready   = 1'b0;
      resp_valid  = 1'b0;
      alu_val1    = '0;
      alu_val2    = '0;
      alu_exe_cmd = CmdNone;
      alu_sr      = 4'b0000;
      unique case (state_q)
         StIdle: begin
            req_ready = 1'b1;
            if (req_valid) state_d = StLo;
         end
         StLo: begin
            alu_val1 = a_q[W-1:0];
            alu_val2 = b_q[W-1:0];
            unique case (op_q)
               OpAdd:   alu_exe_cmd = CmdAdd;
               OpSub:   alu_exe_cmd = CmdSub;
               OpAnd:   alu_exe_cmd = CmdAnd;
               default: alu_exe_cmd = CmdOrr;
            endcase
            state_d = StHi;
         end
         StHi: begin
            alu_val1 = a_q[2*W-1:W];
            alu_val2 = b_q[2*W-1:W];
            unique case (op_q)
               OpAdd: begin
                  alu_exe_cmd = CmdAdc;
                  alu_sr[2]   = lo_c_q;
               end
               OpSub: begin
                  // ALU cout is a borrow, while SBC wants cin=1 for "no borrow".
                  alu_exe_cmd = CmdSbc;
                  alu_sr[2]   = ~lo_c_q;
               end
               OpAnd:   alu_exe_cmd = CmdAnd;
               default: alu_exe_cmd = CmdOrr;
            endcase
            state_d = StDone;
         end
         StDone: begin
            resp_valid = 1'b1;
            if (resp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= 2'b00;
         lo_res_q <= '0;
         lo_z_q   <= 1'b0;
         lo_c_q   <= 1'b0;
         res_q    <= '0;
         status_q <= 4'b0000;
      end else begin
         if (state_q == StIdle && req_valid) begin
            a_q  <= req_a;
            b_q  <= req_b;
            op_q <= req_op;
         end
         if (state_q == StLo) begin
            lo_res_q <= alu_result;
            lo_z_q   <= alu_status[3];
            lo_c_q   <= alu_status[2];
         end
         if (state_q == StHi) begin
            res_q       <= {alu_result, lo_res_q};
            status_q[3] <= lo_z_q & alu_status[3];
            status_q[2] <= is_logic_op ? 1'b0 : alu_status[2];
            status_q[1] <= alu_status[1];
            status_q[0] <= is_logic_op ? 1'b0 : alu_status[0];
         end
      end
   end

   assign resp_result = res_q;
   assign resp_status = status_q;

endmodule

// File: tb/tb_alu_dword_sequencer.sv
module tb_alu_dword_sequencer;

   logic        clk, rst_n;
   logic        req_valid, req_ready;
   logic [1:0]  req_op;
   logic [63:0] req_a, req_b;
   logic        resp_valid, resp_ready;
   logic [63:0] resp_result;
   logic [3:0]  resp_status;
   logic [31:0] alu_val1, alu_val2, alu_result;
   logic [3:0]  alu_exe_cmd, alu_sr, alu_status;

   int checks = 0;
   int passes = 0;

   // Expected responses: {status, result}
   logic [67:0] exp_q[$];

   alu_dword_sequencer #(.W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_result(resp_result), .resp_status(resp_status),
      .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_exe_cmd(alu_exe_cmd), .alu_sr(alu_sr),
      .alu_result(alu_result), .alu_status(alu_status)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stub 32-bit ALU. Logic ops report c=v=1 on purpose so the sequencer's masking shows.
   logic [32:0] t;
   logic        vf;
   always_comb begin
      t  = '0;
      vf = 1'b0;
      case (alu_exe_cmd)
         4'b0010: t = {1'b0, alu_val1} + {1'b0, alu_val2};
         4'b0011: t = {1'b0, alu_val1} + {1'b0, alu_val2} + {32'b0, alu_sr[2]};
         4'b0100: t = {1'b0, alu_val1} - {1'b0, alu_val2};
         4'b0101: t = {1'b0, alu_val1} - {1'b0, alu_val2} - 33'd1 + {32'b0, alu_sr[2]};
         4'b0110: t = {1'b0, alu_val1 & alu_val2};
         4'b0111: t = {1'b0, alu_val1 | alu_val2};
         default: t = '0;
      endcase
      case (alu_exe_cmd)
         4'b0010, 4'b0011:
            vf = (alu_val1[31] == alu_val2[31]) && (t[31] != alu_val1[31]);
         4'b0100, 4'b0101:
            vf = (alu_val1[31] != alu_val2[31]) && (t[31] != alu_val1[31]);
         4'b0110, 4'b0111: vf = 1'b1;
         default: vf = 1'b0;
      endcase
      alu_result = t[31:0];
      alu_status = {t[31:0] == 32'd0,
                    (alu_exe_cmd == 4'b0110 || alu_exe_cmd == 4'b0111) ? 1'b1 : t[32],
                    t[31], vf};
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Monitor: pops an expectation whenever a response is transferred.
   always @(negedge clk) begin
      if (rst_n && resp_valid && resp_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_resp: got result 0x%0h status %b, expected no response",
                     resp_result, resp_status);
         end else begin
            logic [67:0] e;
            e = exp_q.pop_front();
            chk("resp_result", resp_result, e[63:0]);
            chk("resp_status", {60'd0, resp_status}, {60'd0, e[67:64]});
         end
      end
   end

   // Issue one op, check the ALU drive in LO and HI and the response timing.
   // Entered and left at posedge+1; on return the DUT has just entered DONE.
   task automatic issue(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [3:0] lo_cmd, input logic [3:0] hi_cmd,
                        input logic [3:0] hi_sr, input logic [63:0] exp_res,
                        input logic [3:0] exp_stat);
      exp_q.push_back({exp_stat, exp_res});
      chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
      @(posedge clk); #1;
      // Scramble inputs to prove the captured operands are held.
      req_valid = 1'b0; req_op = ~op; req_a = ~a; req_b = ~b;
      chk("lo_cmd", {60'd0, alu_exe_cmd}, {60'd0, lo_cmd});
      chk("lo_sr", {60'd0, alu_sr}, 64'd0);
      chk("lo_vals", {alu_val1, alu_val2}, {a[31:0], b[31:0]});
      chk("lo_valid", {63'd0, resp_valid}, 64'd0);
      @(posedge clk); #1;
      chk("hi_cmd", {60'd0, alu_exe_cmd}, {60'd0, hi_cmd});
      chk("hi_sr", {60'd0, alu_sr}, {60'd0, hi_sr});
      chk("hi_vals", {alu_val1, alu_val2}, {a[63:32], b[63:32]});
      chk("hi_valid", {63'd0, resp_valid}, 64'd0);
      @(posedge clk); #1;
      chk("done_valid", {63'd0, resp_valid}, 64'd1);
      chk("done_cmd", {60'd0, alu_exe_cmd}, 64'd0);
   endtask

   task automatic to_idle();
      @(posedge clk); #1;
      chk("back_idle", {62'd0, req_ready, resp_valid}, 64'd2);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_a = '0; req_b = '0;
      resp_ready = 1'b1;
      #2;
      chk("rst_outs", {resp_result}, 64'd0);
      chk("rst_ctrl", {58'd0, req_ready, resp_valid, resp_status},
          {58'd0, 1'b1, 1'b0, 4'b0000});
      chk("rst_alu", {alu_val1, alu_val2}, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      issue(2'b00, 64'h00000000_FFFFFFFF, 64'h1, 4'b0010, 4'b0011, 4'b0100,
            64'h00000001_00000000, 4'b0000);
      to_idle();
      issue(2'b01, 64'h00000001_00000000, 64'h1, 4'b0100, 4'b0101, 4'b0000,
            64'h00000000_FFFFFFFF, 4'b0000);
      to_idle();
      issue(2'b01, 64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0, 4'b0100, 4'b0101, 4'b0100,
            64'h0, 4'b1000);
      to_idle();
      issue(2'b00, 64'h7FFFFFFF_FFFFFFFF, 64'h1, 4'b0010, 4'b0011, 4'b0100,
            64'h80000000_00000000, 4'b0011);
      to_idle();
      issue(2'b10, 64'hFFFF0000_0000FFFF, 64'h0F0F0F0F_0F0F0F0F, 4'b0110, 4'b0110, 4'b0000,
            64'h0F0F0000_00000F0F, 4'b0000);
      to_idle();
      issue(2'b11, 64'hFFFF0000_0000FFFF, 64'h0F0F0F0F_0F0F0F0F, 4'b0111, 4'b0111, 4'b0000,
            64'hFFFF0F0F_0F0FFFFF, 4'b0010);
      to_idle();

      // Back-pressure: response held, extra request ignored.
      resp_ready = 1'b0;
      issue(2'b00, 64'd5, 64'd7, 4'b0010, 4'b0011, 4'b0000, 64'd12, 4'b0000);
      for (int i = 0; i < 5; i++) begin
         chk("hold_ctrl", {62'd0, req_ready, resp_valid}, 64'd1);
         chk("hold_result", resp_result, 64'd12);
         chk("hold_alu", {56'd0, alu_exe_cmd, alu_sr}, 64'd0);
         if (i == 1) begin
            req_valid = 1'b1; req_op = 2'b11; req_a = 64'hDEAD; req_b = 64'hBEEF;
         end else begin
            req_valid = 1'b0;
         end
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      to_idle();

      // Reset during HI: everything clears, no response.
      req_valid = 1'b1; req_op = 2'b00; req_a = 64'h1234; req_b = 64'h5678;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      chk("pre_rst_hi", {60'd0, alu_exe_cmd}, 64'd3);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_alu", {alu_val1, alu_val2}, 64'd0);
      chk("async_rst_ctrl", {54'd0, req_ready, resp_valid, alu_exe_cmd, alu_sr},
          {54'd0, 1'b1, 1'b0, 8'd0});
      chk("async_rst_resp", {resp_result[59:0], resp_status}, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("post_rst_quiet", {63'd0, resp_valid}, 64'd0);
         @(posedge clk); #1;
      end

      issue(2'b00, 64'd1, 64'd1, 4'b0010, 4'b0011, 4'b0000, 64'd2, 4'b0000);
      to_idle();
      @(posedge clk); #1;
      chk("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
